// File: rtl/wb_pkg.sv
// Shared types for the Wishbone data RAM slave: FSM states, lane width,
// and the byte-lane write-mask helper.
package wb_pkg;

    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_slv_state_e;

    function automatic logic [31:0] wb_lane_mask(
        input logic [WB_SEL_W-1:0] sel
    );
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < WB_SEL_W; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_data_ram_if.sv
// Wishbone B3 classic bus bundle between the core's data master and the RAM.
// Carries o_wb_err only when WB_RAM_ERR_EN is defined.
interface wb_data_ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import wb_pkg::*;

    logic [ADDR_W-1:0]   i_wb_addr;
    logic [DATA_W-1:0]   i_wb_data;
    logic                i_wb_we;
    logic [WB_SEL_W-1:0] i_wb_sel;
    logic                i_wb_stb;
    logic                i_wb_cyc;
    logic [DATA_W-1:0]   o_wb_data;
    logic                o_wb_ack;
`ifdef WB_RAM_ERR_EN
    logic                o_wb_err;
`endif

    modport slave (
`ifdef WB_RAM_ERR_EN
        output o_wb_err,
`endif
        input  i_wb_addr,
        input  i_wb_data,
        input  i_wb_we,
        input  i_wb_sel,
        input  i_wb_stb,
        input  i_wb_cyc,
        output o_wb_data,
        output o_wb_ack
    );

    modport master (
`ifdef WB_RAM_ERR_EN
        input  o_wb_err,
`endif
        output i_wb_addr,
        output i_wb_data,
        output i_wb_we,
        output i_wb_sel,
        output i_wb_stb,
        output i_wb_cyc,
        input  o_wb_data,
        input  o_wb_ack
    );

endinterface

// File: rtl/wb_ram_array.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module wb_ram_array
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [WB_SEL_W-1:0]   i_sel,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [1 << DEPTH_LOG2];
    logic [31:0] r_rdata;
    logic [31:0] w_mask;

    assign w_mask  = wb_lane_mask(i_sel);
    assign o_rdata = r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask)
                               | (i_wdata & w_mask);
            end
            r_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone classic slave data RAM with programmable wait states.
// Define WB_RAM_ERR_EN to error-terminate out-of-range addresses.
module wb_data_ram
    import wb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    wb_data_ram_if.slave bus
);

    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    wb_slv_state_e       r_state;
    wb_slv_state_e       w_state_nx;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nx;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_we;
    logic [WB_SEL_W-1:0] r_sel;

    logic                w_req;
    logic                w_latch;
    logic                w_go_ack;
    logic                w_in_ack;
    logic                w_oob;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_we;
    logic [WB_SEL_W-1:0] w_sel;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_req    = bus.i_wb_cyc & bus.i_wb_stb;
    assign w_in_ack = (r_state == ACK);

    // With zero wait states the access fires from IDLE, before the latch.
    assign w_addr  = (r_state == IDLE) ? bus.i_wb_addr : r_addr;
    assign w_wdata = (r_state == IDLE) ? bus.i_wb_data : r_data;
    assign w_we    = (r_state == IDLE) ? bus.i_wb_we   : r_we;
    assign w_sel   = (r_state == IDLE) ? bus.i_wb_sel  : r_sel;

`ifdef WB_RAM_ERR_EN
    assign w_oob        = |w_addr[ADDR_W-1:DEPTH_LOG2+2];
    assign bus.o_wb_err = w_in_ack & w_oob;
`else
    assign w_oob = 1'b0;
`endif

    assign w_unused = ^{w_addr[1:0], w_addr[ADDR_W-1:DEPTH_LOG2+2]};

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_latch    = 1'b0;
        w_go_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_latch  = 1'b1;
                    w_cnt_nx = WAIT_C;
                    if (WAIT_C == 4'd0) begin
                        w_state_nx = ACK;
                        w_go_ack   = 1'b1;
                    end else begin
                        w_state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.i_wb_cyc) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nx = ACK;
                    w_cnt_nx   = 4'd0;
                    w_go_ack   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            ACK: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_latch) begin
                r_addr <= bus.i_wb_addr;
                r_data <= bus.i_wb_data;
                r_we   <= bus.i_wb_we;
                r_sel  <= bus.i_wb_sel;
            end
        end
    end

    wb_ram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .i_clk  (i_clk),
        .i_en   (w_go_ack & ~w_oob),
        .i_we   (w_we),
        .i_sel  (w_sel),
        .i_addr (w_addr[DEPTH_LOG2+1:2]),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    assign bus.o_wb_ack  = w_in_ack & ~w_oob;
    assign bus.o_wb_data = (w_in_ack & ~w_oob & ~r_we) ? w_rdata : '0;

endmodule

// File: tb/tb_wb_data_ram.sv
// Randomized self-checking bench: three RAM slaves with 0, 1 and 3 wait states
// checked against a word-level memory model.
module tb_wb_data_ram;

`ifdef WB_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] t_addr [3];
    logic [31:0] t_wdata[3];
    logic [31:0] t_rdata[3];
    logic [3:0]  t_sel  [3];
    logic        t_we   [3];
    logic        t_stb  [3];
    logic        t_cyc  [3];
    logic        t_ack  [3];
    logic        t_err  [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [int];

    wb_data_ram_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    wb_data_ram_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    wb_data_ram_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    wb_data_ram #(.WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
    wb_data_ram #(.WAIT_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));
    wb_data_ram #(.WAIT_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus3.slave));

    assign bus0.i_wb_addr = t_addr[0];
    assign bus0.i_wb_data = t_wdata[0];
    assign bus0.i_wb_sel  = t_sel[0];
    assign bus0.i_wb_we   = t_we[0];
    assign bus0.i_wb_stb  = t_stb[0];
    assign bus0.i_wb_cyc  = t_cyc[0];
    assign t_rdata[0]     = bus0.o_wb_data;
    assign t_ack[0]       = bus0.o_wb_ack;

    assign bus1.i_wb_addr = t_addr[1];
    assign bus1.i_wb_data = t_wdata[1];
    assign bus1.i_wb_sel  = t_sel[1];
    assign bus1.i_wb_we   = t_we[1];
    assign bus1.i_wb_stb  = t_stb[1];
    assign bus1.i_wb_cyc  = t_cyc[1];
    assign t_rdata[1]     = bus1.o_wb_data;
    assign t_ack[1]       = bus1.o_wb_ack;

    assign bus3.i_wb_addr = t_addr[2];
    assign bus3.i_wb_data = t_wdata[2];
    assign bus3.i_wb_sel  = t_sel[2];
    assign bus3.i_wb_we   = t_we[2];
    assign bus3.i_wb_stb  = t_stb[2];
    assign bus3.i_wb_cyc  = t_cyc[2];
    assign t_rdata[2]     = bus3.o_wb_data;
    assign t_ack[2]       = bus3.o_wb_ack;

`ifdef WB_RAM_ERR_EN
    assign t_err[0] = bus0.o_wb_err;
    assign t_err[1] = bus1.o_wb_err;
    assign t_err[2] = bus3.o_wb_err;
`else
    assign t_err[0] = 1'b0;
    assign t_err[1] = 1'b0;
    assign t_err[2] = 1'b0;
`endif

    function automatic int waits(input int id);
        return (id == 0) ? 0 : (id == 1) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        t_addr[id]  = a;
        t_wdata[id] = d;
        t_we[id]    = we;
        t_sel[id]   = s;
        t_cyc[id]   = 1'b1;
        t_stb[id]   = 1'b1;
    endtask

    task automatic idle(input int id);
        t_cyc[id] = 1'b0;
        t_stb[id] = 1'b0;
        t_we[id]  = 1'b0;
    endtask

    // One classic transfer; returns cycles from request to termination.
    task automatic xfer(input int id, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output int lat,
                        output logic er);
        drive(id, we, a, d, s);
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (t_ack[id] || t_err[id]) begin
                lat = n;
                rd  = t_rdata[id];
                er  = t_err[id];
                check("ack_err_excl", 32'(t_ack[id] & t_err[id]), 32'd0);
            end else begin
                check("data_gap", t_rdata[id], 32'd0);
            end
        end
        idle(id);
        if (lat == 0) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            check("pulse_ack", 32'(t_ack[id]), 32'd0);
            check("pulse_err", 32'(t_err[id]), 32'd0);
            check("data_after", t_rdata[id], 32'd0);
        end
    endtask

    task automatic op(input int id, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
        int          lat;
        logic        er;
        logic        oob;
        int          key;
        logic [31:0] v;
        xfer(id, we, a, d, s, rd, lat, er);
        oob = ERR_EN && (a[31:14] != 18'd0);
        key = id * 4096 + int'(a[13:2]);
        check("latency", 32'(lat), 32'(waits(id) + 1));
        check("err_flag", 32'(er), 32'(oob));
        if (oob || we) begin
            check("data_zero", rd, 32'd0);
        end
        if (!oob && we) begin
            v = model.exists(key) ? model[key] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            end
            model[key] = v;
        end else if (!oob && model.exists(key)) begin
            check("rdata", rd, model[key]);
        end
    endtask

    logic [31:0] rd;
    int          first;
    int          second;
    int          k;

    initial begin
        for (int i = 0; i < 3; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
            t_sel[i]   = '0;
            idle(i);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ack", 32'(t_ack[i]), 32'd0);
            check("rst_err", 32'(t_err[i]), 32'd0);
            check("rst_data", t_rdata[i], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
        op(1, 1'b0, 32'h10, 32'h0, 4'hF, rd);
        check("deadbeef", rd, 32'hDEADBEEF);

        op(1, 1'b1, 32'h20, 32'h11223344, 4'hF, rd);
        op(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
        op(1, 1'b0, 32'h20, 32'h0, 4'h0, rd);
        check("byte_lanes", rd, 32'h11BB33DD);

        op(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, rd);
        op(0, 1'b0, 32'h30, 32'h0, 4'hF, rd);
        op(2, 1'b1, 32'h30, 32'hFEEDFACE, 4'hF, rd);
        op(2, 1'b0, 32'h30, 32'h0, 4'hF, rd);
        op(0, 1'b1, 32'h34, 32'h01020304, 4'h0, rd);

        // Abort: cyc drops while the slave is still waiting.
        op(2, 1'b1, 32'h40, 32'h76543210, 4'hF, rd);
        drive(2, 1'b1, 32'h40, 32'h55, 4'hF);
        @(posedge clk);
        #1;
        idle(2);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            check("abort_ack", 32'(t_ack[2]), 32'd0);
        end
        op(2, 1'b0, 32'h40, 32'h0, 4'hF, rd);
        check("abort_keep", rd, 32'h76543210);

        // stb drops mid-wait, cyc held: latched request completes.
        drive(2, 1'b1, 32'h44, 32'hCAFEF00D, 4'hF);
        @(posedge clk);
        #1;
        t_stb[2] = 1'b0;
        first = 0;
        for (int n = 2; n <= 10 && first == 0; n++) begin
            @(posedge clk);
            #1;
            if (t_ack[2]) first = n;
        end
        idle(2);
        check("stb_drop_lat", 32'(first), 32'd4);
        model[2 * 4096 + 17] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        op(2, 1'b0, 32'h44, 32'h0, 4'hF, rd);

        // Back-to-back: request held across ACK is re-accepted.
        for (int id = 0; id < 3; id += 2) begin
            drive(id, 1'b0, 32'h30, 32'h0, 4'hF);
            first  = 0;
            second = 0;
            for (int n = 1; n <= 12; n++) begin
                @(posedge clk);
                #1;
                if (t_ack[id]) begin
                    if (first == 0) first = n;
                    else if (second == 0) second = n;
                end
            end
            idle(id);
            check("b2b_first", 32'(first), 32'(waits(id) + 1));
            check("b2b_gap", 32'(second - first), 32'(waits(id) + 2));
            repeat (6) @(posedge clk);
            #1;
        end

        // Reset while waiting: pending write discarded.
        drive(2, 1'b1, 32'h40, 32'h99999999, 4'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_wait_ack", 32'(t_ack[2]), 32'd0);
        idle(2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(2, 1'b0, 32'h40, 32'h0, 4'hF, rd);
        check("rst_discard", rd, 32'h76543210);

        // Reset during ACK: ack drops without waiting for a clock.
        drive(1, 1'b0, 32'h10, 32'h0, 4'hF);
        k = 0;
        for (int n = 1; n <= 10 && k == 0; n++) begin
            @(posedge clk);
            #1;
            if (t_ack[1]) k = n;
        end
        check("pre_rst_ack", 32'(k), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_async_ack", 32'(t_ack[1]), 32'd0);
        check("rst_async_data", t_rdata[1], 32'd0);
        idle(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(1, 1'b0, 32'h10, 32'h0, 4'hF, rd);

        // Out-of-range address: error response or aliasing to word 0.
        op(1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd);
        op(1, 1'b1, 32'h0001_0000, 32'h12345678, 4'hF, rd);
        op(1, 1'b0, 32'h0, 32'h0, 4'hF, rd);
        check("oob_word0", rd, ERR_EN ? 32'hA5A5A5A5 : 32'h12345678);

        for (int id = 0; id < 3; id++) begin
            for (int w = 0; w < 16; w++) begin
                op(id, 1'b1, 32'h400 + 32'(w * 4), $urandom, 4'hF, rd);
            end
            for (int n = 0; n < 60; n++) begin
                logic [31:0] a;
                logic [17:0] up;
                up = ($urandom_range(0, 7) == 0) ?
                     18'($urandom_range(1, 262143)) : 18'd0;
                a  = {up, 12'h100 + 12'($urandom_range(0, 15)),
                      2'($urandom)};
                op(id, 1'($urandom), a, $urandom, 4'($urandom), rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
